four_bit_rca_reg: RTL and testbench

- 4-bit ripple-carry adder with registered outputs: adds 4-bit operands x and y plus a carry-in and produces a 4-bit sum and a carry-out.
- Operands and result are bit-level scalar ports, LSB = index 0.
- Used as the basic adder slice for the 16-bit ripple-carry and carry-select adder datapaths.
- Internally a chain of four full-adder cells followed by one output register stage.

---
 rtl/four_bit_rca_reg_if.sv | 20 ++
 rtl/four_bit_rca_reg.sv | 31 +++
 tb/tb_four_bit_rca_reg.sv | 84 ++++++++
 3 files changed

// File: rtl/four_bit_rca_reg_if.sv
// four_bit_rca_reg_if: bit-level operand/result bundle for the 4-bit registered ripple-carry adder
// Signals: x0..x3, y0..y3 operands (bit 0 = LSB), Cin carry in,
//          s0..s3 sum (bit 0 = LSB), Cout carry out,
//          ovf signed overflow (only when RCA_OVERFLOW_EN is defined).
// master drives operands and reads results; slave is the adder side.
interface four_bit_rca_reg_if;
    logic x0, x1, x2, x3;
    logic y0, y1, y2, y3;
    logic Cin;
    logic s0, s1, s2, s3;
    logic Cout;
`ifdef RCA_OVERFLOW_EN
    logic ovf;
    modport master (output x0, x1, x2, x3, y0, y1, y2, y3, Cin, input s0, s1, s2, s3, Cout, ovf);
    modport slave (input x0, x1, x2, x3, y0, y1, y2, y3, Cin, output s0, s1, s2, s3, Cout, ovf);
`else
    modport master (output x0, x1, x2, x3, y0, y1, y2, y3, Cin, input s0, s1, s2, s3, Cout);
    modport slave (input x0, x1, x2, x3, y0, y1, y2, y3, Cin, output s0, s1, s2, s3, Cout);
`endif
endinterface

// File: rtl/four_bit_rca_reg.sv
// four_bit_rca_reg: 4-bit ripple-carry adder (four full-adder cells) with a registered result
// Ports: clk rising-edge clock; rst synchronous active-high reset;
//        bus (slave) carries x0..x3, y0..y3, Cin in and s0..s3, Cout out.
// Optional: RCA_OVERFLOW_EN adds a registered signed-overflow flag bus.ovf = c3 ^ c4.
module four_bit_rca_reg (
    input logic clk,
    input logic rst,
    four_bit_rca_reg_if.slave bus
);
    logic [3:0] a, b, s, q;
    logic [4:0] c;
    logic co_q;
    assign a = {bus.x3, bus.x2, bus.x1, bus.x0};
    assign b = {bus.y3, bus.y2, bus.y1, bus.y0};
    assign c[0] = bus.Cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i] = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    always_ff @(posedge clk)
        if (rst) {co_q, q} <= '0;
        else {co_q, q} <= {c[4], s};
    assign {bus.Cout, bus.s3, bus.s2, bus.s1, bus.s0} = {co_q, q};
`ifdef RCA_OVERFLOW_EN
    logic ovf_q;
    // overflow when the carry into the sign bit differs from the carry out of it
    always_ff @(posedge clk)
        ovf_q <= rst ? 1'b0 : c[3] ^ c[4];
    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_four_bit_rca_reg.sv
// tb_four_bit_rca_reg: directed and exhaustive self-checking bench for four_bit_rca_reg
module tb_four_bit_rca_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passes = 0;
    int total = 0;
    four_bit_rca_reg_if bus ();
    four_bit_rca_reg dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic step(input logic [3:0] x, input logic [3:0] y, input logic ci, input logic r);
        @(negedge clk);
        {bus.x3, bus.x2, bus.x1, bus.x0} = x;
        {bus.y3, bus.y2, bus.y1, bus.y0} = y;
        bus.Cin = ci;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        got = {bus.Cout, bus.s3, bus.s2, bus.s1, bus.s0};
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

`ifdef RCA_OVERFLOW_EN
    task automatic check_ovf(input string tag, input logic exp);
        total++;
        assert (bus.ovf === exp) passes++;
        else $error("FAIL %s: ovf got %b expected %b", tag, bus.ovf, exp);
    endtask
`endif

    initial begin
        logic [4:0] e;
        step(4'd15, 4'd15, 1'b1, 1'b1); check("reset1", 5'b00000);
        step(4'd15, 4'd15, 1'b1, 1'b1); check("reset2", 5'b00000);
        step(4'd0, 4'd0, 1'b0, 1'b0);   check("zero", 5'b00000);
        step(4'd1, 4'd1, 1'b0, 1'b0);   check("1+1", 5'b00010);
        step(4'd3, 4'd3, 1'b0, 1'b0);   check("3+3", 5'b00110);
        step(4'd1, 4'd0, 1'b1, 1'b0);   check("1+0+c", 5'b00010);
        step(4'd3, 4'd1, 1'b1, 1'b0);   check("3+1+c", 5'b00101);
        // outputs must hold while inputs change between edges
        @(negedge clk);
        {bus.x3, bus.x2, bus.x1, bus.x0} = 4'd15;
        {bus.y3, bus.y2, bus.y1, bus.y0} = 4'd15;
        #1;
        check("hold", 5'b00101);
        step(4'd15, 4'd15, 1'b0, 1'b0); check("15+15", 5'b11110);
        step(4'd13, 4'd9, 1'b0, 1'b0);  check("13+9", 5'b10110);
        step(4'd5, 4'd14, 1'b1, 1'b0);  check("5+14+c", 5'b10100);
        step(4'd14, 4'd9, 1'b1, 1'b0);  check("14+9+c", 5'b11000);
        step(4'd2, 4'd14, 1'b1, 1'b0);  check("2+14+c", 5'b10001);
        step(4'd15, 4'd0, 1'b1, 1'b0);  check("ripple", 5'b10000);
`ifdef RCA_OVERFLOW_EN
        step(4'd7, 4'd1, 1'b0, 1'b0);   check_ovf("ovf7+1", 1'b1); check("7+1", 5'b01000);
        step(4'd8, 4'd8, 1'b0, 1'b0);   check_ovf("ovf8+8", 1'b1); check("8+8", 5'b10000);
        step(4'd3, 4'd2, 1'b0, 1'b0);   check_ovf("ovf3+2", 1'b0); check("3+2", 5'b00101);
`endif
        for (int i = 0; i < 512; i++) begin
            logic [3:0] x, y;
            logic ci;
            {ci, x, y} = 9'(i);
            if (i == 300) begin
                step(x, y, ci, 1'b1);
                check("sweep_rst", 5'b00000);
`ifdef RCA_OVERFLOW_EN
                check_ovf("sweep_rst_ovf", 1'b0);
`endif
            end
            step(x, y, ci, 1'b0);
            e = {1'b0, x} + {1'b0, y} + {4'b0, ci};
            check($sformatf("sweep%0d", i), e);
`ifdef RCA_OVERFLOW_EN
            check_ovf($sformatf("sweep_ovf%0d", i), (x[3] == y[3]) && (e[3] != x[3]));
`endif
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
